level_tracker: RTL

Tracks the player's run state and produces the `cur_level` bus that feeds the LCD controller's score input. It is the consumer of the sequence verifier's result, alongside the game controller. It counts passed puzzles as levels, counts failed attempts as strikes, and flags win or loss. It also keeps a best-level record that survives returns to idle.

---
 rtl/level_tracker.sv | 110 +++++++++++
 1 files changed

// File: rtl/level_tracker.sv
// Level/strike tracker for the puzzle game: turns verifier pass/fail edges into a
// BCD level for the LCD score field, a strike count, sticky win/loss flags and a best-level record.
module level_tracker #(
    parameter int unsigned MAX_LEVEL   = 20,
    parameter int unsigned MAX_STRIKES = 3,
    parameter logic [7:0]  ST_IDLE     = 8'h00,
    parameter logic [7:0]  ST_PLAY     = 8'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] game_state,
    input  logic [1:0] verifier_result,
    output logic [7:0] cur_level,
    output logic [7:0] best_level,
    output logic [1:0] strikes,
    output logic       level_up,
    output logic       game_won,
    output logic       game_lost
);

    localparam logic [1:0] RES_PASS = 2'b01;
    localparam logic [1:0] RES_FAIL = 2'b10;

    logic [1:0] prev_result_q, prev_result_d;
    logic [6:0] level_q, level_d;
    logic [7:0] cur_level_q, cur_level_d;
    logic [7:0] best_level_q, best_level_d;
    logic [1:0] strikes_q, strikes_d;
    logic       level_up_q, level_up_d;
    logic       game_won_q, game_won_d;
    logic       game_lost_q, game_lost_d;

    logic pass_evt;
    logic fail_evt;
    logic run_active;

    // A result held for many cycles counts once: only the first cycle of a value is an event.
    assign pass_evt   = (verifier_result == RES_PASS) && (prev_result_q != RES_PASS);
    assign fail_evt   = (verifier_result == RES_FAIL) && (prev_result_q != RES_FAIL);
    assign run_active = (game_state == ST_PLAY) && !game_won_q && !game_lost_q;

    always_comb begin
        prev_result_d = verifier_result;
        level_d       = level_q;
        cur_level_d   = cur_level_q;
        strikes_d     = strikes_q;
        level_up_d    = 1'b0;
        game_won_d    = game_won_q;
        game_lost_d   = game_lost_q;
        best_level_d  = (cur_level_q > best_level_q) ? cur_level_q : best_level_q;

        if (game_state == ST_IDLE) begin
            level_d     = 7'd1;
            cur_level_d = 8'h01;
            strikes_d   = 2'd0;
            game_won_d  = 1'b0;
            game_lost_d = 1'b0;
        end else if (run_active) begin
            if (pass_evt) begin
                if (level_q < 7'(MAX_LEVEL)) begin
                    level_d    = level_q + 7'd1;
                    level_up_d = 1'b1;
                    // Decimal carry: units roll 9 -> 0 and bump the tens digit.
                    if (cur_level_q[3:0] == 4'd9) begin
                        cur_level_d = {cur_level_q[7:4] + 4'd1, 4'd0};
                    end else begin
                        cur_level_d = {cur_level_q[7:4], cur_level_q[3:0] + 4'd1};
                    end
                end else begin
                    game_won_d = 1'b1;
                end
            end else if (fail_evt) begin
                strikes_d = strikes_q + 2'd1;
                if (strikes_q + 2'd1 == 2'(MAX_STRIKES)) begin
                    game_lost_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_result_q <= 2'b00;
            level_q       <= 7'd1;
            cur_level_q   <= 8'h01;
            best_level_q  <= 8'h00;
            strikes_q     <= 2'd0;
            level_up_q    <= 1'b0;
            game_won_q    <= 1'b0;
            game_lost_q   <= 1'b0;
        end else begin
            prev_result_q <= prev_result_d;
            level_q       <= level_d;
            cur_level_q   <= cur_level_d;
            best_level_q  <= best_level_d;
            strikes_q     <= strikes_d;
            level_up_q    <= level_up_d;
            game_won_q    <= game_won_d;
            game_lost_q   <= game_lost_d;
        end
    end

    assign cur_level  = cur_level_q;
    assign best_level = best_level_q;
    assign strikes    = strikes_q;
    assign level_up   = level_up_q;
    assign game_won   = game_won_q;
    assign game_lost  = game_lost_q;

endmodule
